// File: rtl/mem_multi_bank_clr.sv
// Multi-bank simple dual-port memory with a clear sequencer (power-on and
// software-requested) and a read pipeline qualified by dob_valid.
module mem_multi_bank_clr #(
    parameter int unsigned           DATA_WIDTH    = 8,
    parameter int unsigned           DEPTH         = 32,
    parameter int unsigned           NUM_BANKS     = 4,
    parameter int unsigned           BANK_WIDTH    = $clog2(NUM_BANKS),
    parameter int unsigned           OUTPUT_DELAY  = 1,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wea,
    input  logic [BANK_WIDTH-1:0]    banka,
    input  logic [$clog2(DEPTH)-1:0] addra,
    input  logic [DATA_WIDTH-1:0]    dia,
    input  logic                     reb,
    input  logic [BANK_WIDTH-1:0]    bankb,
    input  logic [$clog2(DEPTH)-1:0] addrb,
    output logic [DATA_WIDTH-1:0]    dob,
    output logic                     dob_valid,
    input  logic                     clr_req,
    input  logic                     clr_all,
    input  logic [BANK_WIDTH-1:0]    clr_bank,
    output logic                     clr_busy,
    output logic                     clr_done
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam bit          BANK_FULL  = (NUM_BANKS == (32'd1 << BANK_WIDTH));
    localparam bit          ADDR_FULL  = (DEPTH == (32'd1 << ADDR_WIDTH));

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } clr_state_t;

    clr_state_t             state;
    logic [ADDR_WIDTH-1:0]  clr_addr;
    logic [NUM_BANKS-1:0]   clr_mask;
    logic [DATA_WIDTH-1:0]  mem [NUM_BANKS][DEPTH];

    logic                   banka_ok_c;
    logic                   bankb_ok_c;
    logic                   clr_bank_ok_c;
    logic                   addra_ok_c;
    logic                   addrb_ok_c;
    logic                   wr_ok_c;
    logic                   rd_forced_c;
    logic [DATA_WIDTH-1:0]  rd_data_c;

    // Range checks collapse to constants when the select fully covers the array.
    if (BANK_FULL) begin : g_bank_full
        assign banka_ok_c    = 1'b1;
        assign bankb_ok_c    = 1'b1;
        assign clr_bank_ok_c = 1'b1;
    end else begin : g_bank_part
        assign banka_ok_c    = banka < BANK_WIDTH'(NUM_BANKS);
        assign bankb_ok_c    = bankb < BANK_WIDTH'(NUM_BANKS);
        assign clr_bank_ok_c = clr_bank < BANK_WIDTH'(NUM_BANKS);
    end

    if (ADDR_FULL) begin : g_addr_full
        assign addra_ok_c = 1'b1;
        assign addrb_ok_c = 1'b1;
    end else begin : g_addr_part
        assign addra_ok_c = addra < ADDR_WIDTH'(DEPTH);
        assign addrb_ok_c = addrb < ADDR_WIDTH'(DEPTH);
    end

    // The mask stays set through DONE, so user writes to a cleared bank are
    // still dropped on that cycle.
    assign wr_ok_c     = wea && banka_ok_c && addra_ok_c && !clr_mask[banka];
    assign rd_forced_c = !bankb_ok_c || !addrb_ok_c ||
                         ((state == S_CLEAR) && clr_mask[bankb]);
    assign rd_data_c   = rd_forced_c ? DEFAULT_VALUE : mem[bankb][addrb];

    // Clear sequencer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
            clr_mask <= '1;
            clr_busy <= 1'b1;
            clr_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clr_req && (clr_all || clr_bank_ok_c)) begin
                        state    <= S_CLEAR;
                        clr_addr <= '0;
                        clr_mask <= clr_all ? '1 : (NUM_BANKS'(1) << clr_bank);
                        clr_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    clr_addr <= clr_addr + ADDR_WIDTH'(1);
                    if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) begin
                        state    <= S_DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    clr_mask <= '0;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    clr_mask <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    // Storage: clear writes to masked banks, user writes to unmasked ones.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if ((state == S_CLEAR) && clr_mask[b]) begin
                mem[b][clr_addr] <= DEFAULT_VALUE;
            end else if (wr_ok_c && (banka == BANK_WIDTH'(b))) begin
                mem[b][addra] <= dia;
            end
        end
    end

    // Read pipeline; stages only load on a valid read so dob holds otherwise.
    if (OUTPUT_DELAY == 0) begin : g_od0
        assign dob       = rd_data_c;
        assign dob_valid = reb;
    end else if (OUTPUT_DELAY == 1) begin : g_od1
        always_ff @(posedge clk) begin
            if (reset) begin
                dob       <= DEFAULT_VALUE;
                dob_valid <= 1'b0;
            end else begin
                dob_valid <= reb;
                if (reb) begin
                    dob <= rd_data_c;
                end
            end
        end
    end else begin : g_od2
        logic [DATA_WIDTH-1:0] dob_s1;
        logic                  valid_s1;

        always_ff @(posedge clk) begin
            if (reset) begin
                dob_s1    <= DEFAULT_VALUE;
                valid_s1  <= 1'b0;
                dob       <= DEFAULT_VALUE;
                dob_valid <= 1'b0;
            end else begin
                valid_s1  <= reb;
                dob_valid <= valid_s1;
                if (reb) begin
                    dob_s1 <= rd_data_c;
                end
                if (valid_s1) begin
                    dob <= dob_s1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_multi_bank_clr.sv
// Bench for mem_multi_bank_clr: three configurations share one stimulus stream
// and are compared every cycle against a window-based behavioural model.
module tb_mem_multi_bank_clr;

    localparam int          NK   = 3;
    localparam int          MAXC = 4000;
    localparam logic [7:0]  DEF  = 8'h00;

    logic       clk = 1'b0;
    logic       reset;
    logic       wea;
    logic [1:0] banka;
    logic [4:0] addra;
    logic [7:0] dia;
    logic       reb;
    logic [1:0] bankb;
    logic [4:0] addrb;
    logic       clr_req;
    logic       clr_all;
    logic [1:0] clr_bank;

    logic [7:0] dob_o  [NK];
    logic       val_o  [NK];
    logic       busy_o [NK];
    logic       done_o [NK];

    always #5 clk = ~clk;

    mem_multi_bank_clr #(.DATA_WIDTH(8), .DEPTH(32), .NUM_BANKS(4), .OUTPUT_DELAY(2),
                         .DEFAULT_VALUE(DEF)) u_od2 (
        .clk(clk), .reset(reset), .wea(wea), .banka(banka), .addra(addra), .dia(dia),
        .reb(reb), .bankb(bankb), .addrb(addrb), .dob(dob_o[0]), .dob_valid(val_o[0]),
        .clr_req(clr_req), .clr_all(clr_all), .clr_bank(clr_bank),
        .clr_busy(busy_o[0]), .clr_done(done_o[0]));

    mem_multi_bank_clr #(.DATA_WIDTH(8), .DEPTH(32), .NUM_BANKS(4), .OUTPUT_DELAY(1),
                         .DEFAULT_VALUE(DEF)) u_od1 (
        .clk(clk), .reset(reset), .wea(wea), .banka(banka), .addra(addra), .dia(dia),
        .reb(reb), .bankb(bankb), .addrb(addrb), .dob(dob_o[1]), .dob_valid(val_o[1]),
        .clr_req(clr_req), .clr_all(clr_all), .clr_bank(clr_bank),
        .clr_busy(busy_o[1]), .clr_done(done_o[1]));

    mem_multi_bank_clr #(.DATA_WIDTH(8), .DEPTH(18), .NUM_BANKS(4), .OUTPUT_DELAY(0),
                         .DEFAULT_VALUE(DEF)) u_d18 (
        .clk(clk), .reset(reset), .wea(wea), .banka(banka), .addra(addra), .dia(dia),
        .reb(reb), .bankb(bankb), .addrb(addrb), .dob(dob_o[2]), .dob_valid(val_o[2]),
        .clr_req(clr_req), .clr_all(clr_all), .clr_bank(clr_bank),
        .clr_busy(busy_o[2]), .clr_done(done_o[2]));

    // Reference model: memory contents plus the cycle in which the current
    // clear window begins; busy/done/idle follow from plain arithmetic.
    logic [7:0] mm        [NK][4][32];
    int         clr_begin [NK];
    logic [3:0] mmask     [NK];
    int         last_reset = -100;
    int         cyc        = 0;
    bit         model_ok   = 1'b0;

    logic       iss_reb [MAXC];
    logic [7:0] iss_val [NK][MAXC];
    logic [7:0] h_dob   [NK][MAXC];
    logic       h_val   [NK][MAXC];
    logic       h_busy  [NK][MAXC];
    logic       h_done  [NK][MAXC];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] bank;
        logic [4:0] addr;
        logic [7:0] data;
        logic [7:0] exp32;
        logic [7:0] exp18;
    } vec_t;

    vec_t tbl [7];

    function automatic int kdepth(input int k);
        return (k == 2) ? 18 : 32;
    endfunction

    function automatic int kod(input int k);
        return 2 - k;
    endfunction

    function automatic bit m_busy(input int k, input int c);
        return (c >= clr_begin[k]) && (c < clr_begin[k] + kdepth(k));
    endfunction

    function automatic bit m_done(input int k, input int c);
        return c == clr_begin[k] + kdepth(k);
    endfunction

    function automatic bit m_idle(input int k, input int c);
        return c > clr_begin[k] + kdepth(k);
    endfunction

    // Latest read issued at or before c-OD that no reset has since flushed.
    function automatic logic [7:0] exp_dob(input int k, input int c);
        int od = kod(k);
        if (od == 0) return iss_val[k][c];
        for (int j = c - od; j > last_reset && j >= 0; j--) begin
            if (iss_reb[j]) return iss_val[k][j];
        end
        return DEF;
    endfunction

    function automatic logic exp_val(input int k, input int c);
        int od = kod(k);
        if (od == 0) return iss_reb[c];
        if ((c - od) <= last_reset || (c - od) < 0) return 1'b0;
        return iss_reb[c - od];
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s inst=%0d cyc=%0d got=0x%0h want=0x%0h", nm, k, cyc, act, want);
        end
    endtask

    task automatic model_edge();
        int c = cyc;
        logic [3:0] act_mask;
        for (int k = 0; k < NK; k++) begin
            if (m_busy(k, c)) begin
                for (int b = 0; b < 4; b++) begin
                    if (mmask[k][b]) mm[k][b][c - clr_begin[k]] = DEF;
                end
            end
            act_mask = (m_busy(k, c) || m_done(k, c)) ? mmask[k] : 4'b0000;
            if (wea && (int'(addra) < kdepth(k)) && !act_mask[banka]) begin
                mm[k][banka][addra] = dia;
            end
            if (reset) begin
                clr_begin[k] = c + 1;
                mmask[k]     = 4'hF;
            end else if (clr_req && m_idle(k, c)) begin
                clr_begin[k] = c + 1;
                mmask[k]     = clr_all ? 4'hF : (4'b0001 << clr_bank);
            end
        end
        if (reset) begin
            last_reset = c;
            model_ok   = 1'b1;
        end
    endtask

    // One clock cycle: sample/compare on the falling edge, advance the model
    // on the rising edge, then release the caller to drive the next inputs.
    task automatic step();
        if (cyc >= MAXC - 1) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            failures++;
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $fatal(1, "cycle budget exhausted");
        end
        @(negedge clk);
        iss_reb[cyc] = reb;
        for (int k = 0; k < NK; k++) begin
            if ((int'(addrb) >= kdepth(k)) || (m_busy(k, cyc) && mmask[k][bankb]))
                iss_val[k][cyc] = DEF;
            else
                iss_val[k][cyc] = mm[k][bankb][addrb];
            h_dob[k][cyc]  = dob_o[k];
            h_val[k][cyc]  = val_o[k];
            h_busy[k][cyc] = busy_o[k];
            h_done[k][cyc] = done_o[k];
        end
        if (model_ok) begin
            for (int k = 0; k < NK; k++) begin
                chk("clr_busy",  k, 32'(busy_o[k]), 32'(m_busy(k, cyc)));
                chk("clr_done",  k, 32'(done_o[k]), 32'(m_done(k, cyc)));
                chk("dob_valid", k, 32'(val_o[k]),  32'(exp_val(k, cyc)));
                chk("dob",       k, 32'(dob_o[k]),  32'(exp_dob(k, cyc)));
            end
        end
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
    endtask

    task automatic set_idle();
        reset = 1'b0; wea = 1'b0; reb = 1'b0; clr_req = 1'b0; clr_all = 1'b0;
        clr_bank = 2'd0; banka = 2'd0; addra = 5'd0; dia = 8'h00; bankb = 2'd0; addrb = 5'd0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            step();
        end
    endtask

    task automatic do_write(input int b, input int a, input logic [7:0] d);
        set_idle();
        wea = 1'b1; banka = 2'(b); addra = 5'(a); dia = d;
        step();
    endtask

    task automatic do_read(input int b, input int a, output int at);
        set_idle();
        reb = 1'b1; bankb = 2'(b); addrb = 5'(a);
        at = cyc;
        step();
    endtask

    // Counts clr_busy cycles and the clr_done position over n cycles from now.
    task automatic measure_clear(input int n, output int cnt [NK], output int done_at [NK]);
        int c0 = cyc;
        for (int k = 0; k < NK; k++) begin
            cnt[k] = 0;
            done_at[k] = -1;
        end
        for (int i = 0; i < n; i++) begin
            set_idle();
            step();
            for (int k = 0; k < NK; k++) begin
                if (h_busy[k][c0 + i]) cnt[k]++;
                if (h_done[k][c0 + i] && done_at[k] < 0) done_at[k] = i;
            end
        end
    endtask

    initial begin
        int cnt [NK];
        int done_at [NK];
        int at, at0, t0, rd_at, a1, a2, busy_cnt;
        int b2b [4];

        for (int k = 0; k < NK; k++) begin
            clr_begin[k] = -1000;
            mmask[k] = 4'h0;
            for (int b = 0; b < 4; b++)
                for (int a = 0; a < 32; a++) mm[k][b][a] = DEF;
        end

        tbl[0] = '{2'd2, 5'd7,  8'hA5, 8'hA5, 8'hA5};
        tbl[1] = '{2'd0, 5'd0,  8'h11, 8'h11, 8'h11};
        tbl[2] = '{2'd3, 5'd31, 8'hFE, 8'hFE, 8'h00};
        tbl[3] = '{2'd1, 5'd4,  8'h44, 8'h44, 8'h44};
        tbl[4] = '{2'd1, 5'd20, 8'h5A, 8'h5A, 8'h00};
        tbl[5] = '{2'd1, 5'd17, 8'hC3, 8'hC3, 8'hC3};
        tbl[6] = '{2'd0, 5'd4,  8'h33, 8'h33, 8'h33};

        // Power-on clear: two reset cycles, then measure the busy window.
        set_idle();
        reset = 1'b1;
        @(posedge clk);
        #1;
        step();
        step();
        measure_clear(40, cnt, done_at);
        for (int k = 0; k < NK; k++) begin
            chk("por_busy_len", k, 32'(cnt[k]), 32'(kdepth(k)));
            chk("por_done_at",  k, 32'(done_at[k]), 32'(kdepth(k)));
        end
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 32; a++) do_read(b, a, at);
        idle_steps(3);

        // Table: write then read the next cycle; compare at each read latency.
        for (int i = 0; i < 7; i++) begin
            do_write(int'(tbl[i].bank), int'(tbl[i].addr), tbl[i].data);
            do_read(int'(tbl[i].bank), int'(tbl[i].addr), at);
            if (i == 0) at0 = at;
            idle_steps(3);
            for (int k = 0; k < NK; k++) begin
                chk("tbl_dob",   k, 32'(h_dob[k][at + kod(k)]),
                    32'((k == 2) ? tbl[i].exp18 : tbl[i].exp32));
                chk("tbl_valid", k, 32'(h_val[k][at + kod(k)]), 32'd1);
            end
        end
        chk("lat_not_early", 0, 32'(h_val[0][at0 + 1]), 32'd0);
        do_read(1, 4, at);
        idle_steps(1);
        chk("alias_addr4", 2, 32'(h_dob[2][at]), 32'h44);

        // Back-to-back reads of four banks come back in order.
        for (int b = 0; b < 4; b++) do_write(b, 9, 8'(8'h90 + b));
        for (int b = 0; b < 4; b++) begin
            set_idle();
            reb = 1'b1; bankb = 2'(b); addrb = 5'd9;
            b2b[b] = cyc;
            step();
        end
        idle_steps(3);
        for (int b = 0; b < 4; b++) begin
            chk("b2b_dob",   0, 32'(h_dob[0][b2b[b] + 2]), 32'(8'(8'h90 + b)));
            chk("b2b_valid", 0, 32'(h_val[0][b2b[b] + 2]), 32'd1);
        end

        // Single-bank clear with concurrent traffic and an ignored request.
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 32; a++) do_write(b, a, 8'h3C);
        set_idle();
        clr_req = 1'b1; clr_all = 1'b0; clr_bank = 2'd1;
        step();
        t0 = cyc;
        rd_at = 0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            set_idle();
            if (i == 0) begin
                wea = 1'b1; banka = 2'd1; addra = 5'd3; dia = 8'hEE;
                reb = 1'b1; bankb = 2'd1; addrb = 5'd2;
                rd_at = cyc;
            end else if (i == 1) begin
                wea = 1'b1; banka = 2'd3; addra = 5'd5; dia = 8'h77;
            end else if (i == 5) begin
                clr_req = 1'b1; clr_all = 1'b1;
            end
            step();
            if (h_busy[0][t0 + i]) busy_cnt++;
        end
        chk("busy_ignore_req", 0, 32'(busy_cnt), 32'd32);
        chk("rd_masked_busy",  1, 32'(h_dob[1][rd_at + 1]), 32'h00);
        do_read(1, 3, a1);
        idle_steps(1);
        chk("cleared_bank1", 1, 32'(h_dob[1][a1 + 1]), 32'h00);
        do_read(0, 3, a1);
        idle_steps(1);
        chk("kept_bank0", 1, 32'(h_dob[1][a1 + 1]), 32'h3C);
        do_read(3, 5, a1);
        idle_steps(1);
        chk("conc_write", 1, 32'(h_dob[1][a1 + 1]), 32'h77);

        // Reset while clr_addr is 10 restarts a full clear.
        set_idle();
        clr_req = 1'b1; clr_all = 1'b1;
        step();
        idle_steps(10);
        set_idle();
        reset = 1'b1;
        step();
        measure_clear(40, cnt, done_at);
        chk("rst_mid_busy", 0, 32'(cnt[0]), 32'd32);
        chk("rst_mid_done", 0, 32'(done_at[0]), 32'd32);

        // Read-during-write: registered ports read first, async port sees new data next cycle.
        do_write(0, 4, 8'h11);
        set_idle();
        wea = 1'b1; banka = 2'd0; addra = 5'd4; dia = 8'h22;
        reb = 1'b1; bankb = 2'd0; addrb = 5'd4;
        a1 = cyc;
        step();
        do_read(0, 4, a2);
        idle_steps(2);
        chk("rdw_old",      1, 32'(h_dob[1][a1 + 1]), 32'h11);
        chk("rdw_new",      1, 32'(h_dob[1][a2 + 1]), 32'h22);
        chk("rdw_async_new", 2, 32'(h_dob[2][a2]),    32'h22);

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            wea      = 1'($urandom);
            banka    = 2'($urandom);
            addra    = 5'($urandom);
            dia      = 8'($urandom);
            reb      = 1'($urandom);
            bankb    = 2'($urandom);
            addrb    = 5'($urandom);
            clr_req  = ($urandom_range(0, 39) == 0);
            clr_all  = 1'($urandom);
            clr_bank = 2'($urandom);
            step();
        end
        idle_steps(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_multi_bank_clr.md
# mem_multi_bank_clr

Multi-bank simple dual-port memory (one write port, one read port, NUM_BANKS banks of DEPTH words) with a built-in clear sequencer and a read-valid pipeline. It is the successor of the plain multi-bank store used for per-channel and per-operator state in the OPL3 datapath. It adds deterministic power-on initialisation, software-requested clearing of one or all banks, and a registered `dob_valid` qualifier. Downstream pipeline stages consume `dob` only when `dob_valid` is high.

## Interface
- `DATA_WIDTH`, 8: word width in bits.
- `DEPTH`, 32: words per bank; need not be a power of two.
- `NUM_BANKS`, 4: bank count, ≥2.
- `BANK_WIDTH`, $clog2(NUM_BANKS): bank-select width.
- `OUTPUT_DELAY`, 1: read latency in cycles; legal values 0, 1, 2. 0 selects an asynchronous read.
- `DEFAULT_VALUE`, 0: value written by the clear sequencer and returned for forced reads.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `wea`  in  1  write enable.
- `banka`  in  BANK_WIDTH  write bank.
- `addra`  in  $clog2(DEPTH)  write address.
- `dia`  in  DATA_WIDTH  write data.
- `reb`  in  1  read enable.
- `bankb`  in  BANK_WIDTH  read bank.
- `addrb`  in  $clog2(DEPTH)  read address.
- `dob`  out  DATA_WIDTH  read data.
- `dob_valid`  out  1  `dob` holds the result of a read issued OUTPUT_DELAY cycles earlier.
- `clr_req`  in  1  single-cycle clear request.
- `clr_all`  in  1  sampled with `clr_req`: 1 clears all banks, 0 clears `clr_bank` only.
- `clr_bank`  in  BANK_WIDTH  bank to clear, sampled with `clr_req`.
- `clr_busy`  out  1  clear sequencer active.
- `clr_done`  out  1  one-cycle pulse on the cycle after the last clear write.

## Operation
- **Sequencer states.**
  - IDLE, CLEAR, DONE.
  - Internal state: `clr_addr` counter, `clr_mask` (NUM_BANKS bits).
- **Reset.**
  - Forces CLEAR with `clr_addr=0` and `clr_mask` all ones, i.e. a power-on clear of every bank.
  - Reset asserted mid-clear restarts this full clear from address 0.
- **IDLE.**
  - `clr_req=1` loads the mask: all ones if `clr_all`, otherwise one-hot at `clr_bank`.
  - Sets `clr_addr=0` and moves to CLEAR.
  - `clr_bank ≥ NUM_BANKS` with `clr_all=0`: request ignored, stay in IDLE.
- **CLEAR.**
  - Each cycle, writes DEFAULT_VALUE at `clr_addr` into every masked bank, then increments `clr_addr`.
  - After the write at DEPTH-1, moves to DONE.
- **DONE.**
  - Lasts one cycle, with `clr_done=1`.
  - Returns to IDLE and clears the mask.
- **`clr_busy`.** 1 in CLEAR, 0 in IDLE and DONE.
- **`clr_req` handling.** Ignored in CLEAR and DONE; requests are not queued.
- **User writes.**
  - Performed when `wea=1`, `banka < NUM_BANKS`, `addra < DEPTH`, and the target bank is not masked.
  - Writes to a masked bank during CLEAR are dropped.
  - Writes to unmasked banks proceed concurrently with clearing.
- **User reads.**
  - A read addressing a masked bank while `clr_busy=1` returns DEFAULT_VALUE.
  - A read with an out-of-range bank or address returns DEFAULT_VALUE.
  - Masked-ness is evaluated in the issue cycle.
- **Read-during-write, same bank and address, OUTPUT_DELAY ≥ 1.** Returns the old data (read-first).
- **Read-during-write, OUTPUT_DELAY = 0.** `dob` reflects the new data after the write edge.
- **Gated reads.** `reb=0` does not update the bank output registers; `dob` holds its last value.

## Timing
- **Read latency.**
  - OUTPUT_DELAY=0: `dob` is combinational from `bankb`/`addrb`; `dob_valid = reb` combinationally.
  - OUTPUT_DELAY=N (1 or 2): a read issued in cycle t appears on `dob` with `dob_valid=1` in cycle t+N.
  - The bank select is pipelined alongside, so back-to-back reads to different banks are returned in order, one per cycle.
- **Write latency.** A write at edge t is visible to a read issued in cycle t+1.
- **Reset values.**
  - `dob_valid=0`.
  - Registered `dob` = DEFAULT_VALUE (OUTPUT_DELAY ≥ 1).
  - `clr_busy=1` from the first cycle after reset.
  - `clr_done=0`.
- **Clear duration.**
  - A clear accepted at edge t performs writes at edges t+1 … t+DEPTH.
  - `clr_busy` is high in cycles t+1 … t+DEPTH.
  - `clr_done` is high in cycle t+DEPTH+1.
  - The earliest next accepted request is at edge t+DEPTH+2.
- **After reset.** Reset deasserted in cycle 0 gives `clr_busy` over cycles 0 … DEPTH-1 and `clr_done` in cycle DEPTH.
- **Simultaneous events.**
  - `reset` with `clr_req`: reset wins.
  - `clr_req` in IDLE with a same-cycle user write to the target bank: the write completes, then the clear overwrites it.

## Test plan
- **Power-on clear.** Defaults, reset for 2 cycles, then release. `clr_busy` is high for exactly 32 cycles and `clr_done` pulses in cycle 32. Reads of every bank and address return 0.
- **Write/read latency.** DATA_WIDTH=8, OUTPUT_DELAY=2. Write 0xA5 to bank 2 addr 7, then read it next cycle. `dob=0xA5` with `dob_valid=1` exactly 2 cycles after `reb`. Back-to-back reads of banks 0–3 return in order.
- **Single-bank clear.** Fill all banks with 0x3C, then `clr_req` with `clr_bank=1`, `clr_all=0`. Writes to bank 1 during busy are dropped; a write of 0x77 to bank 3 addr 5 succeeds. Reads of bank 1 during busy return 0. Afterwards bank 1 reads 0, banks 0/2/3 read 0x3C, and bank 3 addr 5 reads 0x77.
- **Request while busy and reset mid-clear.**
  - A `clr_req` issued 5 cycles into a clear is ignored: `clr_busy` duration stays 32.
  - Reset asserted at `clr_addr=10` restarts a full 32-cycle all-bank clear.
- **Read-during-write.** OUTPUT_DELAY=1, addr 4 holds 0x11. Write 0x22 and read the same address in the same cycle. `dob=0x11`; a read next cycle returns 0x22.
- **Non-power-of-two depth.** DEPTH=18, OUTPUT_DELAY=0. `clr_busy` lasts 18 cycles. A read at addr 20 returns DEFAULT_VALUE; a write at addr 20 does not alter addr 4 (aliasing check).
